byte_negate_serial: RTL

Sequential two's-complement finishing stage placed directly downstream of the byte inverter in the arithmetic datapath. It accepts the already-inverted byte (~x), adds 1 by iterating over small bit slices, and returns -x together with carry and overflow flags. A valid/ready handshake is used on both sides, so it can be chained with registers and adders in the ALU.

---
 rtl/byte_negate_serial.sv | 101 ++++++++++
 1 files changed

// File: rtl/byte_negate_serial.sv
// Serial +1 finishing stage for two's-complement negation: takes ~x, returns -x
// with carry/ovf. Optional overflow flag enabled by defining NEG_OVF_EN.
module byte_negate_serial #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in0,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out,
   output logic       carry,
   output logic       ovf
);
   localparam int B = BITS_PER_CYCLE;
   localparam int N = 8 / B;
   localparam logic [2:0] LAST = 3'(N - 1);

   generate
      if (!(B == 1 || B == 2 || B == 4 || B == 8)) begin : g_bad_bpc
         $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state_q;
   logic [7:0] opnd_q;
   logic [7:0] acc_q;
   logic [7:0] acc_d;
   logic [7:0] out_q;
   logic [2:0] idx_q;
   logic       cy_q;
   logic       carry_q;
   logic [B:0] sum;

   // One slice of the ripple add; acc_d merges it into the working result.
   always_comb begin
      sum   = {1'b0, opnd_q[idx_q*B +: B]} + {{B{1'b0}}, cy_q};
      acc_d = acc_q;
      acc_d[idx_q*B +: B] = sum[B-1:0];
   end

`ifdef NEG_OVF_EN
   logic ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opnd_q  <= 8'h00;
         acc_q   <= 8'h00;
         idx_q   <= 3'd0;
         cy_q    <= 1'b0;
         out_q   <= 8'h00;
         carry_q <= 1'b0;
`ifdef NEG_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               opnd_q  <= in0;
               acc_q   <= 8'h00;
               cy_q    <= 1'b1;
               idx_q   <= 3'd0;
               state_q <= RUN;
            end
            RUN: begin
               acc_q <= acc_d;
               cy_q  <= sum[B];
               idx_q <= idx_q + 3'd1;
               // Output registers load only on completion so they hold across IDLE/RUN.
               if (idx_q == LAST) begin
                  state_q <= DONE;
                  out_q   <= acc_d;
                  carry_q <= sum[B];
`ifdef NEG_OVF_EN
                  ovf_q   <= (acc_d == 8'h80) && (opnd_q == 8'h7F);
`endif
               end
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out       = out_q;
   assign carry     = carry_q;
`ifdef NEG_OVF_EN
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule
